// File: rtl/gcd_rr_scheduler.sv
// gcd_rr_scheduler: round-robin sharing of one sequential GCD engine among N_REQ requesters
module gcd_rr_scheduler #(
  parameter int N_REQ = 4,
  parameter int W = 32,
  parameter int IDW = 2,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid_i,
  output logic [N_REQ-1:0]   req_ready_o,
  input  logic [N_REQ*W-1:0] req_a_i,
  input  logic [N_REQ*W-1:0] req_b_i,
  output logic               rsp_valid_o,
  input  logic               rsp_ready_i,
  output logic [IDW-1:0]     rsp_id_o,
  output logic [W-1:0]       rsp_gcd_o,
  output logic [CNT_W-1:0]   rsp_cycles_o,
  output logic               busy_o,
  output logic               eng_load_o,
  output logic [W-1:0]       eng_a_o,
  output logic [W-1:0]       eng_b_o,
  input  logic [W-1:0]       eng_gcd_i,
  input  logic               eng_done_i
);
  typedef enum logic [1:0] {IDLE, LOAD, WAIT, RESP} state_t;
  state_t state;
  logic [IDW-1:0] rr_ptr, grant;
  logic found;
  logic [N_REQ-1:0][W-1:0] a_arr, b_arr;
  assign a_arr = req_a_i;
  assign b_arr = req_b_i;
  // scan downwards so the last hit is the closest valid requester at or after rr_ptr
  always_comb begin
    logic [IDW-1:0] k;
    grant = '0;
    found = 1'b0;
    k = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      k = IDW'((int'(rr_ptr) + i) % N_REQ);
      if (req_valid_i[k]) begin
        grant = k;
        found = 1'b1;
      end
    end
  end
  assign req_ready_o = (state == IDLE && found && !rst) ? (N_REQ'(1) << grant) : '0;
  assign rsp_valid_o = state == RESP;
  assign busy_o = state != IDLE;
  assign eng_load_o = state == LOAD;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      rr_ptr <= '0;
      rsp_id_o <= '0;
      rsp_gcd_o <= '0;
      rsp_cycles_o <= '0;
      eng_a_o <= '0;
      eng_b_o <= '0;
    end else begin
      case (state)
        IDLE: if (found) begin
          state <= LOAD;
          rsp_id_o <= grant;
          eng_a_o <= a_arr[grant];
          eng_b_o <= b_arr[grant];
        end
        LOAD: begin
          state <= WAIT;
          rsp_cycles_o <= '0;
        end
        WAIT: begin
          rsp_cycles_o <= (&rsp_cycles_o) ? rsp_cycles_o : rsp_cycles_o + 1'b1;
          if (eng_done_i) begin
            rsp_gcd_o <= eng_gcd_i;
            state <= RESP;
          end
        end
        RESP: if (rsp_ready_i) begin
          rr_ptr <= (rsp_id_o == IDW'(N_REQ - 1)) ? '0 : rsp_id_o + 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_gcd_rr_scheduler.sv
// tb_gcd_rr_scheduler: table, directed and randomized checks of the round-robin GCD scheduler
module tb_gcd_rr_scheduler;
  localparam int N = 4, W = 32, IDW = 2, CW = 8;
  localparam logic [N-1:0] ONE = 1;
  typedef struct { int id; logic [W-1:0] a, b, g; int c, lat; } vec_t;
  logic clk = 0, rst = 1;
  logic [N-1:0] req_valid = '0, req_ready;
  logic [N-1:0][W-1:0] a_v, b_v;
  logic rsp_valid, rsp_ready = 1;
  logic [IDW-1:0] rsp_id;
  logic [W-1:0] rsp_gcd;
  logic [CW-1:0] rsp_cycles;
  logic busy, eng_load, eng_done;
  logic [W-1:0] eng_a, eng_b, eng_gcd;
  int tests = 0, fails = 0, cyc = 0, rsp_count = 0, extra = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  gcd_rr_scheduler #(.N_REQ(N), .W(W), .IDW(IDW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_a_i(a_v), .req_b_i(b_v), .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_id_o(rsp_id), .rsp_gcd_o(rsp_gcd), .rsp_cycles_o(rsp_cycles), .busy_o(busy),
    .eng_load_o(eng_load), .eng_a_o(eng_a), .eng_b_o(eng_b),
    .eng_gcd_i(eng_gcd), .eng_done_i(eng_done));

  // engine: one Euclid step per cycle, optional extra stall after reaching b==0
  logic [W-1:0] ex, ey;
  int stall;
  always @(posedge clk or posedge rst)
    if (rst) begin ex <= '0; ey <= '0; stall <= 0; end
    else if (eng_load) begin ex <= eng_a; ey <= eng_b; stall <= extra; end
    else if (ey != 0) begin ex <= ey; ey <= ex % ey; end
    else if (stall > 0) stall <= stall - 1;
  assign eng_done = ey == 0 && stall == 0;
  assign eng_gcd = ex;

  function automatic logic [W-1:0] ref_gcd(logic [W-1:0] a, logic [W-1:0] b);
    logic [W-1:0] t;
    while (b != 0) begin t = a % b; a = b; b = t; end
    return a;
  endfunction
  function automatic int ref_steps(logic [W-1:0] a, logic [W-1:0] b);
    int n = 0;
    logic [W-1:0] t;
    while (b != 0) begin t = a % b; a = b; b = t; n++; end
    return n;
  endfunction
  function automatic int rr_pick(logic [N-1:0] v, int p);
    for (int i = 0; i < N; i++) if (v[(p + i) % N]) return (p + i) % N;
    return -1;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // scoreboard: expected grant, result and latency derived from the request at accept time
  int m_ptr = 0, m_id = 0, m_raw = 0, acc_cyc = 0;
  logic [W-1:0] m_gcd = '0;
  logic inflight = 0, seen = 0;
  int acc_q[$];
  always @(negedge clk) begin
    if (rst) begin
      inflight = 0;
      m_ptr = 0;
    end else begin
      if (req_ready != 0) begin
        check("ready_onehot", 64'($onehot(req_ready)), 1);
        check("ready_only_idle", {inflight, busy}, 0);
        m_id = rr_pick(req_valid, m_ptr);
        check("rr_grant", req_ready, ONE << m_id);
        m_gcd = ref_gcd(a_v[m_id], b_v[m_id]);
        m_raw = ref_steps(a_v[m_id], b_v[m_id]) + 1 + extra;
        acc_cyc = cyc;
        inflight = 1;
        seen = 0;
        acc_q.push_back(m_id);
      end
      if (rsp_valid) begin
        check("rsp_expected", inflight, 1);
        if (!seen) begin
          seen = 1;
          check("rsp_latency", cyc - acc_cyc, 2 + m_raw);
        end
        check("rsp_id", rsp_id, m_id);
        check("rsp_gcd", rsp_gcd, m_gcd);
        check("rsp_cycles", rsp_cycles, m_raw > 255 ? 255 : m_raw);
        if (rsp_ready) begin
          m_ptr = (m_id + 1) % N;
          inflight = 0;
          rsp_count++;
        end
      end
    end
  end

  task automatic wait_rsp(input int n);
    int t = 0;
    while (rsp_count < n && t < 3000) begin @(posedge clk); t++; end
    check("wait_rsp", rsp_count >= n, 1);
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    int t0, n;
    @(posedge clk); #1;
    a_v[v.id] = v.a;
    b_v[v.id] = v.b;
    req_valid = ONE << v.id;
    n = 0;
    do begin @(negedge clk); n++; end while (req_ready == 0 && n < 50);
    check("vec_accept", req_ready, ONE << v.id);
    t0 = cyc;
    @(posedge clk); #1 req_valid = '0;
    n = 0;
    do begin @(negedge clk); n++; end while (!rsp_valid && n < 400);
    check("vec_latency", cyc - t0, v.lat);
    check("vec_id", rsp_id, v.id);
    check("vec_gcd", rsp_gcd, v.g);
    check("vec_cycles", rsp_cycles, v.c);
    @(posedge clk);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[7];
    int base, n;
    logic [N-1:0] g;
    tbl[0] = '{0, 48, 18, 6, 4, 6};
    tbl[1] = '{1, 77, 0, 77, 1, 3};
    tbl[2] = '{1, 0, 0, 0, 1, 3};
    tbl[3] = '{2, 0, 35, 35, 2, 4};
    tbl[4] = '{3, 100, 75, 25, 3, 5};
    tbl[5] = '{2, 13, 13, 13, 2, 4};
    tbl[6] = '{0, 17, 5, 1, 4, 6};
    for (int k = 0; k < N; k++) begin a_v[k] = 12; b_v[k] = 8; end
    req_valid = '1;
    repeat (2) @(negedge clk);
    check("rst_ready", req_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_eng_load", eng_load, 0);
    check("rst_eng_a", eng_a, 0);
    check("rst_rsp_gcd", rsp_gcd, 0);
    check("rst_rsp_cycles", rsp_cycles, 0);
    @(posedge clk); #1 rst = 0;
    wait_rsp(5);
    req_valid = '0;
    for (int i = 0; i < 5; i++) check("order_all_valid", i < acc_q.size() ? acc_q[i] : -1, i % N);
    for (int i = 0; i < 7; i++) run_vec(tbl[i]);
    acc_q.delete();
    base = rsp_count;
    @(posedge clk); #1;
    a_v[0] = 30; b_v[0] = 12; a_v[2] = 81; b_v[2] = 27;
    req_valid = 4'b0101;
    wait_rsp(base + 2);
    req_valid = '0;
    check("order_ptr1_first", acc_q.size() > 0 ? acc_q[0] : -1, 2);
    check("order_ptr1_second", acc_q.size() > 1 ? acc_q[1] : -1, 0);
    acc_q.delete();
    base = rsp_count;
    @(posedge clk); #1;
    rsp_ready = 0;
    a_v[1] = 48; b_v[1] = 18; a_v[3] = 1071; b_v[3] = 462;
    req_valid = 4'b1010;
    n = 0;
    do begin @(negedge clk); n++; end while (!rsp_valid && n < 100);
    for (int i = 0; i < 5; i++) begin
      check("hold_valid", rsp_valid, 1);
      check("hold_busy", busy, 1);
      check("hold_no_ready", req_ready, 0);
      check("hold_id", rsp_id, 1);
      check("hold_gcd", rsp_gcd, 6);
      check("hold_cycles", rsp_cycles, 4);
      @(negedge clk);
    end
    @(posedge clk); #1;
    rsp_ready = 1;
    req_valid[1] = 0;
    wait_rsp(base + 2);
    req_valid = '0;
    check("order_after_hold", acc_q.size() > 1 ? acc_q[1] : -1, 3);
    @(posedge clk); #1;
    a_v[2] = 1071; b_v[2] = 462;
    req_valid = ONE << 2;
    n = 0;
    do begin @(negedge clk); n++; end while (req_ready == 0 && n < 50);
    @(posedge clk); #1 req_valid = '0;
    @(posedge clk);
    @(posedge clk); #1;
    check("pre_rst_busy", busy, 1);
    rst = 1;
    @(negedge clk);
    check("midrst_busy", busy, 0);
    check("midrst_rsp_valid", rsp_valid, 0);
    check("midrst_eng_load", eng_load, 0);
    check("midrst_eng_a", eng_a, 0);
    check("midrst_eng_b", eng_b, 0);
    check("midrst_rsp_id", rsp_id, 0);
    check("midrst_rsp_cycles", rsp_cycles, 0);
    repeat (2) @(posedge clk);
    #1 rst = 0;
    base = rsp_count;
    repeat (10) @(negedge clk);
    check("no_rsp_after_rst", rsp_count, base);
    run_vec('{3, 1071, 462, 21, 4, 6});
    extra = 300;
    run_vec('{2, 9, 0, 9, 255, 303});
    extra = 0;
    base = rsp_count;
    n = 0;
    while (rsp_count < base + 40 && n < 20000) begin
      @(negedge clk);
      g = req_ready;
      @(posedge clk); #1;
      rsp_ready = $urandom_range(0, 3) != 0;
      for (int k = 0; k < N; k++)
        if (!req_valid[k] || g[k]) begin
          req_valid[k] = $urandom_range(0, 2) == 0;
          a_v[k] = $urandom_range(0, 3) == 0 ? 0 : $urandom_range(1, 100000);
          b_v[k] = $urandom_range(0, 3) == 0 ? 0 : $urandom_range(1, 100000);
        end
      n++;
    end
    check("rand_count", rsp_count >= base + 40, 1);
    req_valid = '0;
    rsp_ready = 1;
    n = 0;
    while (inflight && n < 2000) begin @(posedge clk); n++; end
    check("drain", inflight, 0);
    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
